dispense_sequencer: RTL and testbench
=====================================

# dispense_sequencer

Downstream stage of the coin-summing controller. Consumes its one-cycle dispense pulse and drives the physical brew sequence: cup drop, timed valve pour, done indication. Guards against a missing or removed cup with a latched fault. Buffers at most one request that arrives while a brew is in progress.

## Interface
- CUP_CYCLES, default 4: cycles cup_drop is asserted; must be ≥1.
- POUR_CYCLES, default 16: cycles valve_open is asserted; must be ≥1.
- DONE_CYCLES, default 8: cycles led_green is asserted after a pour; must be ≥1.
- CNT_W, default 8: phase counter width; must hold max(CUP,POUR,DONE)−1.
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  reset; synchronous and active-high.
- dispense_req  input  1  one-cycle pulse from the coin controller; level held longer is treated as one request per cycle.
- cup_ok  input  1  cup-present sensor, already synchronous to clk.
- fault_clr  input  1  operator acknowledge; clears FAULT.
- busy  output  1  high in CUP, POUR, DONE.
- cup_drop  output  1  cup release solenoid.
- valve_open  output  1  brew valve.
- led_yellow  output  1  brewing indicator; high in CUP and POUR.
- led_green  output  1  drink ready; high in DONE.
- fault  output  1  high in FAULT.
- served_cnt  output  8  completed dispenses, wraps 255→0.

## Operation
- States: IDLE, CUP, POUR, DONE, FAULT. All outputs are decoded from registered state only (Moore).
- Phase counter is loaded with N−1 on entry to CUP/POUR/DONE and decrements each cycle. The phase ends on the cycle the counter is 0.
- IDLE: dispense_req=1 → CUP.
- CUP: at the last CUP cycle, cup_ok=1 → POUR, else → FAULT.
- POUR: cup_ok is sampled every cycle; cup_ok=0 → FAULT immediately. At the last cycle with cup_ok=1 → DONE, and served_cnt increments on this transition.
- DONE: at the last cycle, (pending | dispense_req) → CUP and pending clears; else → IDLE.
- Pending flag (1 bit):
  - Set by dispense_req in CUP, POUR, or DONE.
  - A request while pending=1 is dropped.
  - A request in DONE's last cycle is served directly and does not set pending.
- FAULT:
  - valve_open, cup_drop, and led_yellow are 0.
  - pending clears on entry.
  - dispense_req is ignored.
  - fault_clr=1 → IDLE.
- served_cnt: 8-bit unsigned, modulo 256, unaffected by FAULT.

## Timing
- Reset: state IDLE, counter 0, pending 0, served_cnt 0, every output 0, effective the cycle after rst is sampled high.
- rst overrides all other inputs in any state, including mid-pour: valve_open is 0 the next cycle.
- Request at cycle t (sampled at edge ending t), defaults:
  - cup_drop: t+1..t+4.
  - valve_open: t+5..t+20.
  - led_green: t+21..t+28.
  - busy: t+1..t+28.
  - served_cnt updates: visible at t+21.
  - IDLE: at t+29 if nothing is pending.
- Back-to-back: with pending set, the next CUP starts at t+29. Throughput is one drink per CUP+POUR+DONE cycles.
- Fault latency: one cycle from the sampled cup_ok=0 to fault=1 and valve_open=0.
- fault_clr: IDLE the next cycle. A dispense_req in that same cycle is dropped; a request the cycle after is accepted.

## Test plan
- Reset: assert rst 2 cycles mid-POUR → next cycle all outputs 0, served_cnt=0, state IDLE; a request at the following cycle starts CUP normally.
- Single dispense: cup_ok=1, req at cycle 0 →
  - cup_drop on cycles 1–4, valve_open on 5–20, led_green on 21–28.
  - busy on 1–28, served_cnt=1 from cycle 21, IDLE at 29.
- Queued request: req at 0 and 10, cup_ok=1 → second CUP on 29–32, second pour on 33–48, served_cnt=2 at 49. An extra req at 12 is dropped, so served_cnt ends at 2.
- Missing cup: cup_ok=0 throughout, req at 0 →
  - cup_drop on 1–4, fault=1 from 5, valve_open never asserts.
  - req at 8 is ignored.
  - fault_clr at 12 → IDLE at 13, fault=0, served_cnt=0.
- Cup removed: cup_ok drops to 0 at cycle 10 → valve_open=0 and fault=1 at cycle 11, pending cleared, served_cnt unchanged.
- Wrap: 256 completed dispenses → served_cnt reads 255 after the 255th and 0 after the 256th.

Source files
------------

// File: rtl/dispense_sequencer_if.sv
// rtl/dispense_sequencer_if.sv - request, sensor and indicator signals of the dispense sequencer
interface dispense_sequencer_if;
    logic       dispense_req;
    logic       cup_ok;
    logic       fault_clr;
    logic       busy;
    logic       cup_drop;
    logic       valve_open;
    logic       led_yellow;
    logic       led_green;
    logic       fault;
    logic [7:0] served_cnt;

    modport master (
        output dispense_req, cup_ok, fault_clr,
        input  busy, cup_drop, valve_open, led_yellow, led_green, fault, served_cnt
    );

    modport slave (
        input  dispense_req, cup_ok, fault_clr,
        output busy, cup_drop, valve_open, led_yellow, led_green, fault, served_cnt
    );
endinterface

// File: rtl/dispense_sequencer.sv
// rtl/dispense_sequencer.sv - cup drop, timed pour and done sequencing with cup fault guard
module dispense_sequencer #(
    parameter int CUP_CYCLES  = 4,
    parameter int POUR_CYCLES = 16,
    parameter int DONE_CYCLES = 8,
    parameter int CNT_W       = 8
) (
    input logic                 clk,
    input logic                 rst,
    dispense_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CUP   = 3'd1,
        POUR  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CUP_LAST  = CNT_W'(CUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] POUR_LAST = CNT_W'(POUR_CYCLES - 1);
    localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_CYCLES - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             pending;
    logic             pending_next;
    logic [7:0]       served;
    logic [7:0]       served_next;
    logic             phase_end;

    assign phase_end = (cnt == '0);

    // State, phase counter, pending flag and served counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= 1'b0;
            served  <= 8'd0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            pending <= pending_next;
            served  <= served_next;
        end
    end

    // Next-state logic; a phase counter reload always accompanies entry into a timed state
    always_comb begin
        state_next   = state;
        cnt_next     = (cnt != '0) ? cnt - 1'b1 : '0;
        pending_next = pending;
        served_next  = served;
        unique case (state)
            IDLE: begin
                if (bus.dispense_req) begin
                    state_next = CUP;
                    cnt_next   = CUP_LAST;
                end
            end
            CUP: begin
                if (bus.dispense_req) begin
                    pending_next = 1'b1;
                end
                if (phase_end) begin
                    if (bus.cup_ok) begin
                        state_next = POUR;
                        cnt_next   = POUR_LAST;
                    end else begin
                        state_next   = FAULT;
                        pending_next = 1'b0;
                    end
                end
            end
            POUR: begin
                if (bus.dispense_req) begin
                    pending_next = 1'b1;
                end
                if (!bus.cup_ok) begin
                    state_next   = FAULT;
                    pending_next = 1'b0;
                end else if (phase_end) begin
                    state_next  = DONE;
                    cnt_next    = DONE_LAST;
                    served_next = served + 8'd1;
                end
            end
            DONE: begin
                if (phase_end) begin
                    // A request on the last cycle is served directly instead of being queued
                    if (pending || bus.dispense_req) begin
                        state_next   = CUP;
                        cnt_next     = CUP_LAST;
                        pending_next = 1'b0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (bus.dispense_req) begin
                    pending_next = 1'b1;
                end
            end
            FAULT: begin
                cnt_next = '0;
                if (bus.fault_clr) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                cnt_next     = '0;
                pending_next = 1'b0;
            end
        endcase
    end

    // Moore output decode from the registered state only
    always_comb begin
        bus.busy       = (state == CUP) || (state == POUR) || (state == DONE);
        bus.cup_drop   = (state == CUP);
        bus.valve_open = (state == POUR);
        bus.led_yellow = (state == CUP) || (state == POUR);
        bus.led_green  = (state == DONE);
        bus.fault      = (state == FAULT);
        bus.served_cnt = served;
    end

endmodule

// File: tb/tb_dispense_sequencer.sv
// tb/tb_dispense_sequencer.sv - scoreboard bench for dispense_sequencer
module tb_dispense_sequencer;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dispense_sequencer_if bus ();

    dispense_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [13:0] exp_q[$];

    logic req_s [0:127];
    logic cup_s [0:127];
    logic clr_s [0:127];
    logic rst_s [0:127];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [13:0] observed();
        return {bus.busy, bus.cup_drop, bus.valve_open, bus.led_yellow,
                bus.led_green, bus.fault, bus.served_cnt};
    endfunction

    task automatic push_exp(input logic b, input logic c, input logic v, input logic y,
                            input logic g, input logic f, input logic [7:0] s);
        exp_q.push_back({b, c, v, y, g, f, s});
    endtask

    // j: cycle index within one brew (1..28), 0 means idle
    task automatic push_phase(input int j, input logic [7:0] s);
        push_exp(j >= 1 && j <= 28, j >= 1 && j <= 4, j >= 5 && j <= 20,
                 j >= 1 && j <= 20, j >= 21 && j <= 28, 1'b0, s);
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 128; i++) begin
            req_s[i] = 1'b0;
            cup_s[i] = 1'b1;
            clr_s[i] = 1'b0;
            rst_s[i] = 1'b0;
        end
    endtask

    task automatic idle_inputs();
        rst              = 1'b0;
        bus.dispense_req = 1'b0;
        bus.cup_ok       = 1'b1;
        bus.fault_clr    = 1'b0;
    endtask

    task automatic run(input string tag, input int n);
        logic [13:0] e;
        for (int c = 0; c < n; c++) begin
            rst              = rst_s[c];
            bus.dispense_req = req_s[c];
            bus.cup_ok       = cup_s[c];
            bus.fault_clr    = clr_s[c];
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) begin
                check_eq($sformatf("%s_underflow c%0d", tag, c + 1), 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq($sformatf("%s c%0d", tag, c + 1), {18'd0, observed()}, {18'd0, e});
            end
        end
        idle_inputs();
        exp_q.delete();
    endtask

    initial begin
        int w;
        logic [13:0] e;

        rst              = 1'b1;
        bus.dispense_req = 1'b0;
        bus.cup_ok       = 1'b1;
        bus.fault_clr    = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        check_eq("reset_state", {18'd0, observed()}, 32'd0);

        // Reset mid-pour, then a normal start
        clear_sched();
        req_s[0] = 1'b1; rst_s[8] = 1'b1; rst_s[9] = 1'b1; req_s[12] = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            if (k <= 8)       push_phase(k, 8'd0);
            else if (k <= 12) push_phase(0, 8'd0);
            else              push_phase(k - 12, 8'd0);
        end
        run("midpour_reset", 20);

        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check_eq("reset_again", {18'd0, observed()}, 32'd0);

        // Single dispense
        clear_sched();
        req_s[0] = 1'b1;
        for (int k = 1; k <= 30; k++) push_phase(k <= 28 ? k : 0, k >= 21 ? 8'd1 : 8'd0);
        run("single", 30);

        // Queued request plus a dropped extra
        clear_sched();
        req_s[0] = 1'b1; req_s[10] = 1'b1; req_s[12] = 1'b1;
        for (int k = 1; k <= 58; k++) begin
            logic [7:0] s;
            s = (k >= 49) ? 8'd3 : (k >= 21) ? 8'd2 : 8'd1;
            if (k <= 28)      push_phase(k, s);
            else if (k <= 56) push_phase(k - 28, s);
            else              push_phase(0, s);
        end
        run("queued", 58);

        // Missing cup, ignored request, clear with a same-cycle dropped request
        clear_sched();
        req_s[0] = 1'b1; req_s[8] = 1'b1; req_s[12] = 1'b1; req_s[13] = 1'b1;
        clr_s[12] = 1'b1;
        for (int i = 0; i < 13; i++) cup_s[i] = 1'b0;
        for (int k = 1; k <= 43; k++) begin
            if (k <= 4)       push_phase(k, 8'd3);
            else if (k <= 12) push_exp(0, 0, 0, 0, 0, 1, 8'd3);
            else if (k == 13) push_phase(0, 8'd3);
            else if (k <= 41) push_phase(k - 13, k >= 34 ? 8'd4 : 8'd3);
            else              push_phase(0, 8'd4);
        end
        run("missing_cup", 43);

        // Cup removed mid-pour; pending must not survive the fault
        clear_sched();
        req_s[0] = 1'b1; req_s[7] = 1'b1; cup_s[10] = 1'b0; clr_s[14] = 1'b1; req_s[16] = 1'b1;
        for (int k = 1; k <= 46; k++) begin
            if (k <= 10)      push_phase(k, 8'd4);
            else if (k <= 14) push_exp(0, 0, 0, 0, 0, 1, 8'd4);
            else if (k <= 16) push_phase(0, 8'd4);
            else if (k <= 44) push_phase(k - 16, k >= 37 ? 8'd5 : 8'd4);
            else              push_phase(0, 8'd5);
        end
        run("cup_removed", 46);

        // Wrap of served_cnt over 256 completed dispenses
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        check_eq("wrap_start", {24'd0, bus.served_cnt}, 32'd0);
        for (int i = 0; i < 256; i++) begin
            bus.dispense_req = 1'b1;
            exp_q.push_back({6'd0, 8'((i + 1) % 256)});
            @(posedge clk);
            #2;
            bus.dispense_req = 1'b0;
            w = 0;
            while (!bus.led_green && w < 40) begin
                @(posedge clk);
                #2;
                w++;
            end
            e = exp_q.pop_front();
            if (w >= 40) check_eq($sformatf("wrap_timeout_done %0d", i), 32'd0, 32'd1);
            else check_eq($sformatf("wrap_served %0d", i + 1), {24'd0, bus.served_cnt}, {24'd0, e[7:0]});
            w = 0;
            while (bus.busy && w < 40) begin
                @(posedge clk);
                #2;
                w++;
            end
            if (w >= 40) check_eq($sformatf("wrap_timeout_idle %0d", i), 32'd0, 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
